// File: rtl/expr_solver_pkg.sv
// Shared types and constants for the expression-solver scheduler and its bench.
package expr_solver_pkg;

    localparam int DEF_DATA_W = 8;
    // Cycles the solver needs after start before it raises completed.
    localparam int SOLVER_LAT = 6;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        RESP,
        CLEAR
    } sched_state_t;

endpackage

// File: rtl/expr_solver_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any_req
);

    localparam int ID_W = $clog2(N_REQ);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        // Walk offsets from farthest to nearest so the nearest set request wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/expr_solver_scheduler.sv
// Round-robin scheduler sharing one expression solver among N_REQ requesters,
// with start/complete handshake, timeout abort and a solver clear after every answer.
module expr_solver_scheduler
    import expr_solver_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_CYC = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_x,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         slv_x,
    output logic                      slv_start,
    output logic                      slv_clr,
    input  logic                      slv_completed,
    input  logic [DATA_W-1:0]         slv_result,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TMO_CYC);

    if (N_REQ < 2 || TMO_CYC < SOLVER_LAT + 2) begin : g_param_check
        $error("expr_solver_scheduler: N_REQ must be >= 2 and TMO_CYC >= SOLVER_LAT + 2");
    end

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] slv_x_q, slv_x_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic              slv_start_q, slv_start_d;
    logic              slv_clr_q, slv_clr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // Output strobes are computed one state ahead so each is a clean register bit.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_id_d      = cur_id_q;
        cnt_d         = cnt_q;
        slv_x_d       = slv_x_q;
        req_ready_d   = '0;
        slv_start_d   = 1'b0;
        slv_clr_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = '0;
        rsp_data_d    = '0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d     = GRANT;
                    req_ready_d = arb_grant;
                    slv_x_d     = req_x[arb_idx*DATA_W +: DATA_W];
                    cur_id_d    = arb_idx;
                    rr_ptr_d    = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                end
            end
            GRANT: begin
                state_d     = START;
                slv_start_d = 1'b1;
            end
            START: begin
                // A completed flag seen here is left over from before the start; ignore it.
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (slv_completed) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_data_d  = slv_result;
                end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = cur_id_q;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d   = CLEAR;
                slv_clr_d = 1'b1;
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cur_id_q      <= '0;
            cnt_q         <= '0;
            slv_x_q       <= '0;
            req_ready_q   <= '0;
            slv_start_q   <= 1'b0;
            slv_clr_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_id_q      <= cur_id_d;
            cnt_q         <= cnt_d;
            slv_x_q       <= slv_x_d;
            req_ready_q   <= req_ready_d;
            slv_start_q   <= slv_start_d;
            slv_clr_q     <= slv_clr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign slv_x       = slv_x_q;
    assign slv_start   = slv_start_q;
    assign slv_clr     = slv_clr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_expr_solver_scheduler.sv
// Scoreboard bench for expr_solver_scheduler: behavioural solver model, round-robin
// reference, per-requester expected-response queues and a decoupled output monitor.
module tb_expr_solver_scheduler;
    import expr_solver_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 15;
    localparam int ID_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_x;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       slv_x;
    logic                    slv_start;
    logic                    slv_clr;
    logic                    slv_completed;
    logic [DATA_W-1:0]       slv_result;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_timeout;
    logic                    busy;

    expr_solver_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_ready     (req_ready),
        .slv_x         (slv_x),
        .slv_start     (slv_start),
        .slv_clr       (slv_clr),
        .slv_completed (slv_completed),
        .slv_result    (slv_result),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] res;
        bit                tmo;
    } exp_t;

    exp_t exp_q[N_REQ][$];
    int   rsp_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Mode flags for the solver model, set by the stimulus process.
    bit sol_never = 1'b0;
    bit sol_stale = 1'b0;

    function automatic logic [DATA_W-1:0] sol_f(input logic [DATA_W-1:0] v);
        return DATA_W'(v * v + 3);
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++)
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        return -1;
    endfunction

    task automatic check_eq(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Solver model: completes SOLVER_LAT negedges after seeing start; cleared by slv_clr or rst.
    initial begin
        int          sol_cnt;
        bit          stale_on, stale_drop;
        logic [DATA_W-1:0] sol_x;
        slv_completed = 1'b0;
        slv_result    = '0;
        sol_cnt = 0; stale_on = 1'b0; stale_drop = 1'b0; sol_x = '0;
        forever begin
            @(negedge clk);
            if (rst || slv_clr) begin
                slv_completed = 1'b0; slv_result = '0;
                sol_cnt = 0; stale_on = 1'b0; stale_drop = 1'b0;
            end else begin
                if (sol_stale && req_ready != '0) begin
                    slv_completed = 1'b1; slv_result = 8'hEE; stale_on = 1'b1;
                end
                if (stale_drop) begin
                    slv_completed = 1'b0; stale_drop = 1'b0; stale_on = 1'b0;
                end
                if (slv_start) begin
                    sol_cnt = SOLVER_LAT; sol_x = slv_x; stale_drop = stale_on;
                end else if (sol_cnt > 0) begin
                    sol_cnt--;
                    if (sol_cnt == 0 && !sol_never) begin
                        slv_completed = 1'b1; slv_result = sol_f(sol_x);
                    end
                end
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    int cyc = 0, m_ptr = 0, outstanding = -1, start_cyc = 0;
    int n_start = 0, n_clr = 0, n_rsp = 0;
    bit prev_rsp = 1'b0;

    initial begin
        int   w, g;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                m_ptr = 0; outstanding = -1; prev_rsp = 1'b0;
                for (int i = 0; i < N_REQ; i++) exp_q[i].delete();
            end else begin
                if (req_ready != '0) begin
                    w = rr_pick(req_valid, m_ptr);
                    g = -1;
                    if ($onehot(req_ready))
                        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
                    check_eq("grant_id", g, w);
                    check_eq("grant_while_busy", outstanding, -1);
                    if (g >= 0) begin
                        if (exp_q[g].size() > 0) check_eq("slv_x", int'(slv_x), int'(exp_q[g][0].x));
                        m_ptr = (g + 1) % N_REQ;
                        outstanding = g;
                    end
                end
                if (slv_start) begin
                    n_start++;
                    start_cyc = cyc;
                end
                if (rsp_valid) begin
                    n_rsp++;
                    rsp_log.push_back(int'(rsp_id));
                    check_eq("rsp_id", int'(rsp_id), outstanding);
                    if (outstanding >= 0 && exp_q[outstanding].size() > 0) begin
                        e = exp_q[outstanding].pop_front();
                        check_eq("rsp_data", int'(rsp_data), int'(e.res));
                        check_eq("rsp_timeout", int'(rsp_timeout), int'(e.tmo));
                        if (e.tmo) check_eq("tmo_latency", cyc - start_cyc, TMO_CYC + 1);
                    end
                    outstanding = -1;
                end
                if (slv_clr) begin
                    n_clr++;
                    check_eq("clr_after_rsp", int'(prev_rsp), 1);
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    // Stimulus helpers: all inputs change on the falling edge.
    task automatic tick();
        @(negedge clk);
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic raise(input int i, input logic [DATA_W-1:0] xv);
        exp_t e;
        e.x = xv; e.tmo = sol_never; e.res = sol_never ? '0 : sol_f(xv);
        req_valid[i] = 1'b1;
        req_x[i*DATA_W +: DATA_W] = xv;
        exp_q[i].push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || busy || outstanding >= 0) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_in_budget", int'(n < budget), 1);
        repeat (2) tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_ctrl"}, int'({req_ready, slv_start, slv_clr, rsp_valid, rsp_timeout, busy}), 0);
        check_eq({name, "_data"}, int'({slv_x, rsp_data, rsp_id}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_x = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_s, b_c, b_r, b_l, n, tot;
        rst = 1'b1; req_valid = '0; req_x = '0;
        do_reset();

        // Single request from requester 2.
        b_s = n_start; b_c = n_clr; b_r = n_rsp;
        tick();
        raise(2, 8'd5);
        tick();
        check_eq("t1_ready_next_cycle", int'(req_ready), 4);
        check_eq("t1_busy", int'(busy), 1);
        drain(100);
        check_eq("t1_starts", n_start - b_s, 1);
        check_eq("t1_clears", n_clr - b_c, 1);
        check_eq("t1_rsps", n_rsp - b_r, 1);
        check_eq("t1_rsp_id", rsp_log[rsp_log.size()-1], 2);

        // Solver never completes: timeout response.
        sol_never = 1'b1; b_c = n_clr;
        raise(1, 8'($urandom_range(0, 255)));
        drain(200);
        sol_never = 1'b0;
        check_eq("t3_clear_issued", n_clr - b_c, 1);

        // Stale completed held through START.
        sol_stale = 1'b1;
        raise(0, 8'd9);
        drain(100);
        sol_stale = 1'b0;

        // Requester 1 arrives while 0 is served, requester 3 later.
        b_l = rsp_log.size();
        raise(0, 8'd17);
        n = 0;
        while (req_valid[0] && n < 20) begin tick(); n++; end
        raise(1, 8'd33);
        repeat (4) tick();
        raise(3, 8'd71);
        drain(200);
        check_eq("t5_count", rsp_log.size() - b_l, 3);
        if (rsp_log.size() - b_l >= 3) begin
            check_eq("t5_first", rsp_log[b_l], 0);
            check_eq("t5_second", rsp_log[b_l+1], 1);
            check_eq("t5_third", rsp_log[b_l+2], 3);
        end

        // All requesters continuously valid from reset: strict rotation.
        do_reset();
        b_l = rsp_log.size(); b_r = n_rsp; n = 0;
        while (n_rsp - b_r < 5 && n < 300) begin
            for (int i = 0; i < N_REQ; i++) if (!req_valid[i]) raise(i, 8'($urandom_range(0, 255)));
            tick();
            n++;
        end
        drain(300);
        check_eq("t2_count_ok", int'(rsp_log.size() - b_l >= 5), 1);
        if (rsp_log.size() - b_l >= 5)
            for (int k = 0; k < 5; k++) check_eq("t2_rotation", rsp_log[b_l+k], k % N_REQ);

        // Reset mid-WAIT; next requests served with pointer back at 0.
        sol_never = 1'b1; b_r = n_rsp;
        raise(1, 8'd44);
        n = 0;
        while (!slv_start && n < 20) begin tick(); n++; end
        repeat (3) tick();
        check_eq("t4_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t4_mid_reset");
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sol_never = 1'b0;
        check_eq("t4_no_rsp", n_rsp - b_r, 0);
        b_l = rsp_log.size();
        raise(1, 8'd50);
        raise(3, 8'd60);
        drain(200);
        check_eq("t4_count", rsp_log.size() - b_l, 2);
        if (rsp_log.size() - b_l >= 2) begin
            check_eq("t4_first", rsp_log[b_l], 1);
            check_eq("t4_second", rsp_log[b_l+1], 3);
        end

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < N_REQ; i++)
                if (!req_valid[i] && $urandom_range(0, 5) == 0) raise(i, 8'($urandom_range(0, 255)));
        end
        drain(500);

        tot = 0;
        for (int i = 0; i < N_REQ; i++) tot += exp_q[i].size();
        check_eq("leftover_expected", tot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
